// File: rtl/matrix_cfg_loader.sv
// Serial config front-end for the 5x4 switch matrix: hunts SYNC, fills an 18-word shadow, checks it, commits atomically.
// Commit or reject lands one edge after the last checksum bit; cfg_ready is low only in that CHECK cycle and while rst is high.
module matrix_cfg_loader #(
    parameter int         NTB  = 5,
    parameter int         NLR  = 4,
    parameter int         CW   = 6,
    parameter int         NENT = 2*NTB + 2*NLR,
    parameter logic [7:0] SYNC = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    input  logic                 cfg_data,
    output logic                 cfg_ready,
    input  logic                 cfg_abort,
    output logic [NENT*CW-1:0]   cfg_out,
    output logic                 cfg_done,
    output logic                 cfg_err,
    output logic                 busy,
    output logic [7:0]           err_cnt
);

    localparam int KW = $clog2(NENT + 2);
    localparam int BW = $clog2(CW);

    typedef enum logic [1:0] {ST_SYNC, ST_LOAD, ST_CHECK} state_t;

    state_t              r_state, w_next;
    logic [7:0]          r_window;
    logic [BW-1:0]       r_bit;
    logic [KW-1:0]       r_k;
    logic [CW-1:0]       r_word;
    logic [CW-1:0]       r_csum_run;
    logic [CW-1:0]       r_csum_rx;
    logic                r_legal;
    logic [NENT*CW-1:0]  r_shadow;
    logic [NENT*CW-1:0]  r_cfg_out;
    logic                r_done;
    logic                r_err;
    logic [7:0]          r_err_cnt;

    logic                w_accept;
    logic [7:0]          w_window;
    logic [CW-1:0]       w_word;
    logic                w_word_end;
    logic                w_pass;
    logic                w_commit;
    logic                w_reject;

    // Select 0 leaves a destination undriven, so its index field is don't-care.
    function automatic logic f_legal(input logic [CW-1:0] w);
        case (w[2:0])
            3'd0:       f_legal = 1'b1;
            3'd1, 3'd3: f_legal = int'(w[CW-1:3]) < NTB;
            3'd2, 3'd4: f_legal = int'(w[CW-1:3]) < NLR;
            default:    f_legal = 1'b0;
        endcase
    endfunction

    assign cfg_ready  = !rst && (r_state != ST_CHECK);
    assign busy       = (r_state == ST_LOAD) || (r_state == ST_CHECK);
    assign cfg_out    = r_cfg_out;
    assign cfg_done   = r_done;
    assign cfg_err    = r_err;
    assign err_cnt    = r_err_cnt;

    assign w_accept   = cfg_valid && cfg_ready;
    assign w_window   = {r_window[6:0], cfg_data};
    assign w_word     = {r_word[CW-2:0], cfg_data};
    assign w_word_end = w_accept && !cfg_abort && (r_state == ST_LOAD) && (r_bit == BW'(CW-1));
    assign w_pass     = (r_csum_rx == r_csum_run) && r_legal;

    always_comb begin
        w_next   = r_state;
        w_commit = 1'b0;
        w_reject = 1'b0;
        case (r_state)
            ST_SYNC: begin
                if (w_accept && !cfg_abort && (w_window == SYNC))
                    w_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (cfg_abort)
                    w_next = ST_SYNC;
                else if (w_word_end && (r_k == KW'(NENT)))
                    w_next = ST_CHECK;
            end
            ST_CHECK: begin
                w_next = ST_SYNC;
                if (!cfg_abort) begin
                    w_commit = w_pass;
                    w_reject = !w_pass;
                end
            end
            default: w_next = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_SYNC;
            r_window   <= '0;
            r_bit      <= '0;
            r_k        <= '0;
            r_word     <= '0;
            r_csum_run <= '0;
            r_csum_rx  <= '0;
            r_legal    <= 1'b1;
            r_shadow   <= '0;
            r_cfg_out  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= w_commit;
            r_err   <= w_reject;
            if (w_commit)
                r_cfg_out <= r_shadow;
            if (w_reject && (r_err_cnt != 8'hFF))
                r_err_cnt <= r_err_cnt + 8'd1;

            // Window is zero whenever SYNC is re-entered because it is cleared on the way out.
            if (r_state == ST_SYNC) begin
                if (cfg_abort) begin
                    r_window <= '0;
                end else if (w_accept) begin
                    if (w_window == SYNC) begin
                        r_window   <= '0;
                        r_bit      <= '0;
                        r_k        <= '0;
                        r_csum_run <= '0;
                        r_legal    <= 1'b1;
                    end else begin
                        r_window <= w_window;
                    end
                end
            end

            if ((r_state == ST_LOAD) && w_accept && !cfg_abort) begin
                r_word <= w_word;
                if (w_word_end) begin
                    r_bit <= '0;
                    r_k   <= r_k + KW'(1);
                    if (r_k < KW'(NENT)) begin
                        for (int i = 0; i < NENT; i++)
                            if (r_k == KW'(i))
                                r_shadow[i*CW +: CW] <= w_word;
                        r_csum_run <= r_csum_run ^ w_word;
                        r_legal    <= r_legal && f_legal(w_word);
                    end else begin
                        r_csum_rx <= w_word;
                    end
                end else begin
                    r_bit <= r_bit + BW'(1);
                end
            end
        end
    end

endmodule
